// File: rtl/dense_ocl_slave.sv
// AXI4-Lite responder for the dense layer's OCL register window. Turns host writes
// into single-cycle storage strobes and host reads into fixed-latency output_y fetches.
module dense_ocl_slave #(
    parameter int RD_LAT = 2
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    input  logic [31:0] sh_ocl_awaddr,
    input  logic        sh_ocl_awvalid,
    output logic        cl_ocl_awready,
    input  logic [31:0] sh_ocl_wdata,
    input  logic [3:0]  sh_ocl_wstrb,
    input  logic        sh_ocl_wvalid,
    output logic        cl_ocl_wready,
    output logic [1:0]  cl_ocl_bresp,
    output logic        cl_ocl_bvalid,
    input  logic        sh_ocl_bready,
    input  logic [31:0] sh_ocl_araddr,
    input  logic        sh_ocl_arvalid,
    output logic        cl_ocl_arready,
    output logic [31:0] cl_ocl_rdata,
    output logic [1:0]  cl_ocl_rresp,
    output logic        cl_ocl_rvalid,
    input  logic        sh_ocl_rready,
    output logic        mem_wr_en,
    output logic [1:0]  mem_wr_sel,
    output logic [12:0] mem_wr_idx,
    output logic [31:0] mem_wr_data,
    output logic        mem_rd_en,
    output logic [6:0]  mem_rd_idx,
    input  logic [31:0] mem_rd_data,
    output logic        core_start,
    input  logic        core_busy,
    input  logic        core_done
);
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RK_ERR      = 2'd0;
    localparam logic [1:0] RK_Y        = 2'd1;
    localparam logic [1:0] RK_STATUS   = 2'd2;
    localparam logic [1:0] RK_CTRL     = 2'd3;
    localparam logic [2:0] LAT_LOAD    = 3'(RD_LAT);

    // Word address a = addr[31:2]; result is {legal, is_ctrl, sel[1:0], idx[12:0]}.
    function automatic logic [16:0] wr_decode(input logic [29:0] a, input logic [3:0] strb);
        logic [16:0] r;
        r = '0;
        if (a[29:14] == 16'h0 && strb == 4'hF) begin
            if (a[13:6] == 8'h00)
                r = {1'b1, 1'b0, 2'd0, 7'd0, a[5:0]};
            else if (a[13:8] == 6'h00 && (a[7:6] == 2'b01 || a[7:6] == 2'b10))
                r = {1'b1, 1'b0, 2'd1, 6'd0, a[7], a[5:0]};
            else if (a[13:0] == 14'h0400)
                r = {1'b1, 1'b1, 2'd0, 13'd0};
            else if (a[13])
                r = {1'b1, 1'b0, 2'd2, a[12:0]};
        end
        return r;
    endfunction

    // Result is {kind[1:0], idx[6:0]}.
    function automatic logic [8:0] rd_decode(input logic [29:0] a);
        logic [8:0] r;
        r = {RK_ERR, 7'd0};
        if (a[29:14] == 16'h0) begin
            if (a[13:7] == 7'b0000010)
                r = {RK_Y, a[6:0]};
            else if (a[13:0] == 14'h0401)
                r = {RK_STATUS, 7'd0};
            else if (a[13:0] == 14'h0400)
                r = {RK_CTRL, 7'd0};
        end
        return r;
    endfunction

    wstate_t     wstate;
    rstate_t     rstate;
    logic [29:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        done;
    logic        done_clr;
    logic [2:0]  lat_cnt;

    logic        aw_have, w_have;
    logic [29:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [16:0] wdec;
    logic [8:0]  rdec;
    logic        unused_bits;

    assign unused_bits = ^{sh_ocl_awaddr[1:0], sh_ocl_araddr[1:0]};

    // A half counts as present if already held (ready dropped) or arriving this cycle.
    always_comb begin
        aw_have = !cl_ocl_awready || sh_ocl_awvalid;
        w_have  = !cl_ocl_wready  || sh_ocl_wvalid;
        wr_addr = cl_ocl_awready ? sh_ocl_awaddr[31:2] : awaddr_q;
        wr_data = cl_ocl_wready  ? sh_ocl_wdata : wdata_q;
        wr_strb = cl_ocl_wready  ? sh_ocl_wstrb : wstrb_q;
        wdec    = wr_decode(wr_addr, wr_strb);
        rdec    = rd_decode(sh_ocl_araddr[31:2]);
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            wstate         <= W_IDLE;
            cl_ocl_awready <= 1'b1;
            cl_ocl_wready  <= 1'b1;
            cl_ocl_bvalid  <= 1'b0;
            cl_ocl_bresp   <= RESP_OKAY;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_sel     <= '0;
            mem_wr_idx     <= '0;
            mem_wr_data    <= '0;
            core_start     <= 1'b0;
            done_clr       <= 1'b0;
        end else begin
            mem_wr_en  <= 1'b0;
            core_start <= 1'b0;
            done_clr   <= 1'b0;
            case (wstate)
                W_IDLE: begin
                    if (sh_ocl_awvalid && cl_ocl_awready) begin
                        awaddr_q       <= sh_ocl_awaddr[31:2];
                        cl_ocl_awready <= 1'b0;
                    end
                    if (sh_ocl_wvalid && cl_ocl_wready) begin
                        wdata_q       <= sh_ocl_wdata;
                        wstrb_q       <= sh_ocl_wstrb;
                        cl_ocl_wready <= 1'b0;
                    end
                    if (aw_have && w_have) begin
                        cl_ocl_awready <= 1'b0;
                        cl_ocl_wready  <= 1'b0;
                        mem_wr_en      <= wdec[16] && !wdec[15];
                        core_start     <= wdec[16] && wdec[15] && wr_data[0];
                        done_clr       <= wdec[16] && wdec[15] && wr_data[1];
                        mem_wr_sel     <= wdec[14:13];
                        mem_wr_idx     <= wdec[12:0];
                        mem_wr_data    <= wr_data;
                        cl_ocl_bresp   <= wdec[16] ? RESP_OKAY : RESP_SLVERR;
                        wstate         <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    cl_ocl_bvalid <= 1'b1;
                    wstate        <= W_RESP;
                end
                W_RESP: begin
                    if (sh_ocl_bready) begin
                        cl_ocl_bvalid  <= 1'b0;
                        cl_ocl_awready <= 1'b1;
                        cl_ocl_wready  <= 1'b1;
                        wstate         <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // A completion arriving alongside a clear must not be lost, so set wins.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main)
            done <= 1'b0;
        else
            done <= core_done || (done && !done_clr);
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            rstate         <= R_IDLE;
            cl_ocl_arready <= 1'b1;
            cl_ocl_rvalid  <= 1'b0;
            cl_ocl_rdata   <= '0;
            cl_ocl_rresp   <= RESP_OKAY;
            mem_rd_en      <= 1'b0;
            mem_rd_idx     <= '0;
            lat_cnt        <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (sh_ocl_arvalid) begin
                        cl_ocl_arready <= 1'b0;
                        case (rdec[8:7])
                            RK_Y: begin
                                mem_rd_en  <= 1'b1;
                                mem_rd_idx <= rdec[6:0];
                                lat_cnt    <= LAT_LOAD;
                                rstate     <= R_WAIT;
                            end
                            RK_STATUS: begin
                                cl_ocl_rdata  <= {30'd0, done, core_busy};
                                cl_ocl_rresp  <= RESP_OKAY;
                                cl_ocl_rvalid <= 1'b1;
                                rstate        <= R_RESP;
                            end
                            RK_CTRL: begin
                                cl_ocl_rdata  <= '0;
                                cl_ocl_rresp  <= RESP_OKAY;
                                cl_ocl_rvalid <= 1'b1;
                                rstate        <= R_RESP;
                            end
                            default: begin
                                cl_ocl_rdata  <= '0;
                                cl_ocl_rresp  <= RESP_SLVERR;
                                cl_ocl_rvalid <= 1'b1;
                                rstate        <= R_RESP;
                            end
                        endcase
                    end
                end
                R_WAIT: begin
                    mem_rd_en <= 1'b0;
                    if (lat_cnt == 3'd0) begin
                        cl_ocl_rdata  <= mem_rd_data;
                        cl_ocl_rresp  <= RESP_OKAY;
                        cl_ocl_rvalid <= 1'b1;
                        rstate        <= R_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                R_RESP: begin
                    if (sh_ocl_rready) begin
                        cl_ocl_rvalid  <= 1'b0;
                        cl_ocl_arready <= 1'b1;
                        rstate         <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_ocl_slave.sv
// Scoreboard bench for dense_ocl_slave: expected storage strobes and AXI responses,
// each tagged with the cycle it must appear in, are queued at drive time.
module tb_dense_ocl_slave;
    localparam int RD_LAT = 2;
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } rsp_t;
    typedef struct {
        logic [1:0]  sel;
        logic [12:0] idx;
        logic [31:0] data;
        int          cyc;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, mem_wr_data, mem_rd_data;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp, mem_wr_sel;
    logic [12:0] mem_wr_idx;
    logic [6:0]  mem_rd_idx;
    logic        mem_wr_en, mem_rd_en, core_start, core_busy, core_done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    int   bv_start, rv_start;
    logic bv_prev, rv_prev;
    logic hist_v [0:7];
    logic [6:0] hist_i [0:7];
    rsp_t exp_b[$], exp_r[$];
    mem_t exp_wr[$], exp_rd[$];
    rsp_t er;
    mem_t em;

    dense_ocl_slave #(.RD_LAT(RD_LAT)) dut (
        .clk_main_a0(clk), .rst_main(rst),
        .sh_ocl_awaddr(awaddr), .sh_ocl_awvalid(awvalid), .cl_ocl_awready(awready),
        .sh_ocl_wdata(wdata), .sh_ocl_wstrb(wstrb), .sh_ocl_wvalid(wvalid), .cl_ocl_wready(wready),
        .cl_ocl_bresp(bresp), .cl_ocl_bvalid(bvalid), .sh_ocl_bready(bready),
        .sh_ocl_araddr(araddr), .sh_ocl_arvalid(arvalid), .cl_ocl_arready(arready),
        .cl_ocl_rdata(rdata), .cl_ocl_rresp(rresp), .cl_ocl_rvalid(rvalid), .sh_ocl_rready(rready),
        .mem_wr_en(mem_wr_en), .mem_wr_sel(mem_wr_sel), .mem_wr_idx(mem_wr_idx), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        return exp_b.size() + exp_r.size() + exp_wr.size() + exp_rd.size();
    endfunction

    // Downstream memory model plus monitor, sampled mid-cycle after inputs settle.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                hist_v[k] = 1'b0;
                hist_i[k] = '0;
            end
            mem_rd_data = 32'h0;
            bv_prev = 1'b0;
            rv_prev = 1'b0;
        end else begin
            for (int k = 7; k > 0; k--) begin
                hist_v[k] = hist_v[k-1];
                hist_i[k] = hist_i[k-1];
            end
            hist_v[0] = mem_rd_en;
            hist_i[0] = mem_rd_idx;
            mem_rd_data = hist_v[RD_LAT] ? {16'hCAFE, 9'h0, hist_i[RD_LAT]} : 32'hDEAD_BEEF;
            if (mem_wr_en) begin
                if (exp_wr.size() == 0) check("wr_stray", mem_wr_en, 0);
                else begin
                    em = exp_wr.pop_front();
                    check("wr_sel", mem_wr_sel, em.sel);
                    check("wr_idx", mem_wr_idx, em.idx);
                    check("wr_data", mem_wr_data, em.data);
                    check("wr_cycle", cyc, em.cyc);
                end
            end
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) check("rd_en_stray", mem_rd_en, 0);
                else begin
                    em = exp_rd.pop_front();
                    check("rd_idx", mem_rd_idx, em.idx);
                    check("rd_en_cycle", cyc, em.cyc);
                end
            end
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (bvalid && !bv_prev) bv_start = cyc;
            bv_prev = bvalid;
            if (rvalid && !rv_prev) rv_start = cyc;
            rv_prev = rvalid;
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check("b_stray", bvalid, 0);
                else begin
                    er = exp_b.pop_front();
                    check("bresp", bresp, er.resp);
                    check("bvalid_cycle", bv_start, er.cyc);
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) check("r_stray", rvalid, 0);
                else begin
                    er = exp_r.pop_front();
                    check("rdata", rdata, er.data);
                    check("rresp", rresp, er.resp);
                    check("rvalid_cycle", rv_start, er.cyc);
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_at, input int w_at, input logic [1:0] resp,
                             input logic wr, input logic [1:0] sel, input logic [12:0] idx,
                             output int t_last);
        int   t0, k;
        logic aw_done, w_done;
        rsp_t b;
        mem_t m;
        aw_done = 1'b0;
        w_done  = 1'b0;
        k = 0;
        @(negedge clk);
        t0 = cyc;
        t_last = t0 + ((aw_at > w_at) ? aw_at : w_at);
        b.data = '0; b.resp = resp; b.cyc = t_last + 2;
        exp_b.push_back(b);
        if (wr) begin
            m.sel = sel; m.idx = idx; m.data = d; m.cyc = t_last + 1;
            exp_wr.push_back(m);
        end
        while (!(aw_done && w_done) && k < 20) begin
            if (!aw_done && k >= aw_at) begin awaddr = a; awvalid = 1'b1; end
            if (!w_done && k >= w_at) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
            @(negedge clk);
            k++;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
        end
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input logic y, input logic [6:0] idx);
        int   t0, k;
        rsp_t r;
        mem_t m;
        @(negedge clk);
        t0 = cyc;
        r.data = d; r.resp = resp; r.cyc = t0 + (y ? RD_LAT + 2 : 1);
        exp_r.push_back(r);
        if (y) begin
            m.sel = '0; m.idx = {6'd0, idx}; m.data = '0; m.cyc = t0 + 1;
            exp_rd.push_back(m);
        end
        araddr = a;
        arvalid = 1'b1;
        k = 0;
        while (!arready && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) check("ar_handshake_timeout", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin @(negedge clk); n++; end
        @(negedge clk);
        #3;
        check("drain_pending", pending(), 0);
    endtask

    task automatic pulse_done();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
    endtask

    initial begin
        int   t, k, base;
        mem_t m;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        core_busy = 1'b0; core_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_enables", {mem_wr_en, mem_rd_en, core_start}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        // AW three cycles ahead of W, then W ahead of AW, then map boundaries.
        axi_write(32'h0000_8004, 32'h1234_5678, 4'hF, 0, 3, OKAY, 1, 2'd2, 13'd1, t);
        drain(20);
        axi_write(32'h0000_00FC, 32'hA5A5_0001, 4'hF, 2, 0, OKAY, 1, 2'd0, 13'd63, t);
        drain(20);
        axi_write(32'h0000_02FC, 32'h0000_BEEF, 4'hF, 0, 0, OKAY, 1, 2'd1, 13'd127, t);
        drain(20);
        axi_write(32'h0000_FFFC, 32'h7777_0000, 4'hF, 1, 1, OKAY, 1, 2'd2, 13'd8191, t);
        drain(20);

        // Error writes and reads.
        axi_write(32'h0000_0400, 32'h1, 4'hF, 0, 0, SLVERR, 0, 2'd0, 13'd0, t);
        drain(20);
        axi_write(32'h0000_0010, 32'h2, 4'h3, 0, 0, SLVERR, 0, 2'd0, 13'd0, t);
        drain(20);
        axi_write(32'h0000_0300, 32'h3, 4'hF, 0, 0, SLVERR, 0, 2'd0, 13'd0, t);
        drain(20);
        axi_write(32'h0001_0010, 32'h4, 4'hF, 0, 0, SLVERR, 0, 2'd0, 13'd0, t);
        drain(20);
        axi_read(32'h0000_0000, 32'h0, SLVERR, 0, 7'd0);
        drain(20);
        axi_read(32'h0000_0600, 32'h0, SLVERR, 0, 7'd0);
        drain(20);
        axi_read(32'h0000_1000, 32'h0, OKAY, 0, 7'd0);
        drain(20);
        axi_read(32'h0000_05FC, 32'hCAFE_007F, OKAY, 1, 7'd127);
        drain(20);

        // output_y read with the response held off for five cycles.
        rready = 1'b0;
        axi_read(32'h0000_0408, 32'hCAFE_0002, OKAY, 1, 7'd2);
        k = 0;
        while (!rvalid && k < 20) begin @(negedge clk); k++; end
        repeat (5) begin
            check("r_hold_data", rdata, 32'hCAFE_0002);
            check("r_hold_valid", rvalid, 1);
            @(negedge clk);
        end
        rready = 1'b1;
        drain(20);

        // Start pulse and sticky DONE.
        base = start_cnt;
        axi_write(32'h0000_1000, 32'h1, 4'hF, 0, 0, OKAY, 0, 2'd0, 13'd0, t);
        drain(20);
        check("start_count", start_cnt - base, 1);
        check("start_cycle", start_cyc, t + 1);
        axi_read(32'h0000_1004, 32'h0, OKAY, 0, 7'd0);
        drain(20);
        pulse_done();
        axi_read(32'h0000_1004, 32'h2, OKAY, 0, 7'd0);
        drain(20);
        core_busy = 1'b1;
        axi_read(32'h0000_1004, 32'h3, OKAY, 0, 7'd0);
        drain(20);
        core_busy = 1'b0;
        fork
            axi_write(32'h0000_1000, 32'h2, 4'hF, 0, 0, OKAY, 0, 2'd0, 13'd0, t);
            begin
                @(negedge clk);
                @(negedge clk); core_done = 1'b1;
                @(negedge clk); core_done = 1'b0;
            end
        join
        drain(20);
        axi_read(32'h0000_1004, 32'h2, OKAY, 0, 7'd0);
        drain(20);
        axi_write(32'h0000_1000, 32'h2, 4'hF, 0, 0, OKAY, 0, 2'd0, 13'd0, t);
        drain(20);
        axi_read(32'h0000_1004, 32'h0, OKAY, 0, 7'd0);
        drain(20);
        check("start_count_after_clear", start_cnt - base, 1);

        // Concurrent bias write and STATUS read.
        fork
            axi_write(32'h0000_0100, 32'h0BAD_F00D, 4'hF, 0, 1, OKAY, 1, 2'd1, 13'd0, t);
            axi_read(32'h0000_1004, 32'h0, OKAY, 0, 7'd0);
        join
        drain(20);

        // Reset while the write response is stalled.
        pulse_done();
        bready = 1'b0;
        axi_write(32'h0000_0004, 32'h1111_2222, 4'hF, 0, 0, OKAY, 1, 2'd0, 13'd1, t);
        k = 0;
        while (!bvalid && k < 20) begin @(negedge clk); k++; end
        check("b_before_rst", bvalid, 1);
        rst = 1'b1;
        exp_b.delete();
        #1;
        check("rst_wresp_bvalid", bvalid, 0);
        check("rst_wresp_ready", {awready, wready}, 2'b11);
        check("rst_wresp_enables", {mem_wr_en, core_start}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bready = 1'b1;

        // Reset while an output_y fetch is in flight.
        @(negedge clk);
        t = cyc;
        araddr = 32'h0000_0404;
        arvalid = 1'b1;
        m.sel = '0; m.idx = 13'd1; m.data = '0; m.cyc = t + 1;
        exp_rd.push_back(m);
        @(negedge clk);
        arvalid = 1'b0;
        check("ar_busy_ready", arready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rwait_rvalid", rvalid, 0);
        check("rst_rwait_arready", arready, 1);
        check("rst_rwait_rd_en", mem_rd_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        axi_read(32'h0000_1004, 32'h0, OKAY, 0, 7'd0);
        drain(20);
        axi_write(32'h0000_0008, 32'h3333_4444, 4'hF, 0, 0, OKAY, 1, 2'd0, 13'd2, t);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dense_ocl_slave.md
# dense_ocl_slave

AXI4-Lite responder on the OCL BAR that gives the host register-mapped access to the dense layer: writes to input vector, bias and weight storage, reads of neuron outputs, and a start/done control pair. Sits between the shell's `sh_ocl_*`/`cl_ocl_*` ports and the dense layer's storage and compute array. Storage lives downstream; this block only converts AXI-Lite transactions into single-cycle write strobes and fixed-latency read requests.

## Interface
- `RD_LAT`, default 2: cycles from `mem_rd_en` to valid `mem_rd_data` (1..7).
- `clk_main_a0` in 1: sole clock.
- `rst_main` in 1: asynchronous, active-high reset.
- `sh_ocl_awaddr` in 32, `sh_ocl_awvalid` in 1, `cl_ocl_awready` out 1: write address channel.
- `sh_ocl_wdata` in 32, `sh_ocl_wstrb` in 4, `sh_ocl_wvalid` in 1, `cl_ocl_wready` out 1: write data channel.
- `cl_ocl_bresp` out 2, `cl_ocl_bvalid` out 1, `sh_ocl_bready` in 1: write response.
- `sh_ocl_araddr` in 32, `sh_ocl_arvalid` in 1, `cl_ocl_arready` out 1: read address.
- `cl_ocl_rdata` out 32, `cl_ocl_rresp` out 2, `cl_ocl_rvalid` out 1, `sh_ocl_rready` in 1: read data.
- `mem_wr_en` out 1, `mem_wr_sel` out 2 (0 input_x, 1 bias, 2 weight), `mem_wr_idx` out 13, `mem_wr_data` out 32: storage write port.
- `mem_rd_en` out 1, `mem_rd_idx` out 7, `mem_rd_data` in 32: output_y read port.
- `core_start` out 1: one-cycle start pulse. `core_busy` in 1, `core_done` in 1 (one-cycle pulse).

## Operation
- Address map, `addr[15:0]` decoded, `addr[1:0]` ignored, bits 31:16 must be 0:
  - 0x0000–0x00FC input_x[0..63], write-only, sel 0, idx = addr[7:2].
  - 0x0100–0x02FC biases[0..127], write-only, sel 1, idx = (addr−0x100)>>2.
  - 0x0400–0x05FC output_y[0..127], read-only, idx = addr[8:2].
  - 0x1000 CTRL: write bit0=1 pulses `core_start`; bit1=1 clears DONE. Reads 0.
  - 0x1004 STATUS, read-only: bit0 = `core_busy`, bit1 = DONE sticky, others 0.
  - 0x8000–0xFFFC weights, write-only, sel 2, idx = addr[14:2] (n*64+i).
- Write FSM W_IDLE → W_EXEC → W_RESP → W_IDLE. In W_IDLE AW and W are captured independently in either order; `awready`/`wready` high only while their half is not yet held. Both held → W_EXEC.
- W_EXEC (1 cycle): legal writable address and `wstrb==4'hF` → `mem_wr_en`=1 (or CTRL action), bresp OKAY (0). Otherwise no side effect, bresp SLVERR (2).
- W_RESP: `bvalid` held until `bready`; then W_IDLE.
- Read FSM R_IDLE → R_WAIT → R_RESP. `arready`=1 only in R_IDLE. output_y address: `mem_rd_en` pulse, wait RD_LAT, capture `mem_rd_data`. STATUS: data formed directly, no wait. Write-only/unmapped: rdata 0, rresp SLVERR, no `mem_rd_en`.
- R_RESP: `rvalid` and `rdata` held stable until `rready`.
- Read and write FSMs are independent and may run concurrently.
- DONE set by `core_done`; cleared by CTRL bit1 write; set wins if same cycle.
- Reset mid-transaction abandons it: no pending write is issued, no response is given.

## Timing
- Reset values: all `cl_ocl_*` outputs 0 except `awready`, `wready`, `arready` = 1; `mem_wr_en`, `mem_rd_en`, `core_start`, DONE = 0; FSMs idle.
- Write: last of AW/W handshake at cycle T → `mem_wr_en`/`core_start` at T+1 → `bvalid` at T+2. Throughput at most one write per 3 cycles with `bready` held high.
- Read output_y: AR handshake at T → `mem_rd_en` at T+1 → `mem_rd_data` sampled at T+1+RD_LAT → `rvalid` at T+2+RD_LAT.
- Read STATUS/error: `rvalid` at T+1.
- `mem_wr_*` and `mem_rd_idx` are valid only in their enable cycle; `core_start` is exactly one cycle.

## Test plan
- AW at cycle 0, W at cycle 3, addr 0x8004, data 0x1234_5678, wstrb F → `mem_wr_en` with sel 2, idx 1 at cycle 4; bvalid OKAY at 5.
- Read 0x0408, RD_LAT=2, `mem_rd_data`=0xCAFE_0002 → `mem_rd_en` idx 2 at T+1; rvalid rdata 0xCAFE_0002 OKAY at T+4. Hold rready low 5 cycles → rdata stable.
- Write 0x0400 (read-only) and write 0x0010 with wstrb 4'h3 → SLVERR, no `mem_wr_en`. Read 0x0000 → SLVERR, rdata 0.
- Write CTRL=1 → single `core_start`; `core_done` pulse → STATUS reads 0x2. Write CTRL=2 in the same cycle as a `core_done` pulse → DONE stays 1.
- Concurrent write to 0x0100 and read of 0x1004 → both complete with correct timing; `mem_wr_idx`=0, sel 1.
- Assert `rst_main` during W_RESP and during R_WAIT → `bvalid`/`rvalid` drop immediately; post-reset ready values as specified; no stray enables.
